prim_cmd_sequencer: RTL and testbench
=====================================

Name: prim_cmd_sequencer

Overview:
- Buffers 16-bit primitive-renderer commands from the host register interface in a small FIFO.
- Issues them one per cycle to the primitive renderer (opcode in cmd[15:12]: 0–3 coordinates, 4 colour, F start).
- After issuing a start (opcode F), holds all further issue until the renderer reports line done, so queued coordinates for the next primitive cannot overwrite the one being drawn.
- A watchdog releases a hung WAIT_DONE state. Sits between the register block and the renderer's cmd_i/cmd_valid_i.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- TIMEOUT_CYCLES, 65535, maximum cycles spent in WAIT_DONE before forced release; 0 disables the watchdog.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- cmd_i  input  16  host command word.
- cmd_valid_i  input  1  push cmd_i this cycle.
- cmd_ready_o  output  1  FIFO can accept a push (not full).
- flush_i  input  1  synchronous flush of queue and sequencer state.
- clear_err_i  input  1  clears sticky overflow_o and timeout_o.
- rndr_cmd_o  output  16  command to renderer (renderer cmd_i).
- rndr_cmd_valid_o  output  1  one-cycle strobe qualifying rndr_cmd_o (renderer cmd_valid_i).
- rndr_done_i  input  1  renderer line-complete pulse.
- level_o  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- busy_o  output  1  work pending or in progress.
- overflow_o  output  1  sticky: a push was dropped.
- timeout_o  output  1  sticky: watchdog fired.

Behaviour:
- Reset (async assert, release synchronous to clk): FIFO empty, state ISSUE, watchdog counter 0, rndr_cmd_o=0, rndr_cmd_valid_o=0, level_o=0, busy_o=0, overflow_o=0, timeout_o=0. cmd_ready_o=0 while reset_i is high.
- cmd_ready_o = !full && !reset_i. It is combinational from registered pointers.
- Push: cmd_valid_i && cmd_ready_o writes cmd_i at the tail.
  - cmd_valid_i while full: word dropped, overflow_o set.
  - Push and pop in the same cycle while full: the push is rejected, because ready was low.
- No bypass path. A word pushed into an empty FIFO at edge N is popped at edge N+1; rndr_cmd_valid_o is high during cycle N+2 (2-cycle latency).
- rndr_cmd_o and rndr_cmd_valid_o are registered. rndr_cmd_valid_o is high for exactly one cycle per popped word. rndr_cmd_o holds its last value otherwise.
- State ISSUE:
  - If FIFO not empty: pop the head, one per cycle, back-to-back allowed.
  - If the popped word has cmd[15:12]==4'hF: next state WAIT_DONE and clear the watchdog counter.
  - Otherwise remain in ISSUE.
- State WAIT_DONE:
  - No pops.
  - rndr_done_i=1: next state ISSUE.
  - Otherwise the counter increments. When TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 without done, the next state is ISSUE and timeout_o is set. Exactly TIMEOUT_CYCLES cycles are spent in WAIT_DONE.
  - The counter width is sufficient for TIMEOUT_CYCLES and saturates when the watchdog is disabled.
- rndr_done_i in ISSUE: ignored. Done and timeout in the same cycle: done wins, timeout_o is not set.
- Earliest post-done issue: done sampled at edge M, state ISSUE at M, next pop at edge M+1.
- level_o updates on the same edge as push/pop.
  - Push+pop in the same cycle: level unchanged.
  - Pointers wrap modulo DEPTH; an extra pointer bit distinguishes full from empty.
- busy_o = (state==WAIT_DONE) || !empty || rndr_cmd_valid_o. It is registered-equivalent, with no combinational path from inputs.
- flush_i (synchronous) takes priority over everything:
  - Empties the FIFO, forces ISSUE, clears the counter, forces rndr_cmd_valid_o=0 next cycle.
  - A push in the same cycle is discarded and does not set overflow.
  - Sticky flags are unaffected.
- clear_err_i clears the sticky flags.
  - If a new overflow or timeout occurs in the same cycle, set wins.
  - clear_err_i and flush_i are independent.
- Reset asserted mid-WAIT_DONE or mid-queue: immediate return to reset values. Queued words are lost.

Test Plan:
- Push 0x0010, 0x1020, 0x2030, 0x3040, 0x40FF, 0xF000 back-to-back into an empty FIFO.
  - Strobes appear in the same order on 6 consecutive cycles, the first 2 cycles after the first push.
  - Then state WAIT_DONE, busy_o=1.
- With WAIT_DONE active, push 0x0005.
  - No strobe until rndr_done_i pulses at cycle M; 0x0005 strobes in cycle M+2; busy_o falls the cycle after that strobe.
- DEPTH=8, stalled in WAIT_DONE: push 9 words.
  - cmd_ready_o low after the 8th; level_o=8; the 9th is dropped and overflow_o=1.
  - clear_err_i clears overflow_o; the 8 words drain after done.
- TIMEOUT_CYCLES=16: issue 0xF000, never pulse done.
  - Exactly 16 cycles in WAIT_DONE, then timeout_o=1 and the queue resumes.
  - Repeat with done on the 16th cycle: no timeout_o.
- 5 words queued plus WAIT_DONE: assert flush_i together with a push.
  - Next cycle level_o=0, busy_o=0, no strobe, overflow_o unchanged.
  - A subsequent push issues normally.
- Assert reset_i asynchronously mid-drain (between clock edges).
  - All outputs go to reset values immediately, cmd_ready_o=0.
  - After release, an empty FIFO with cmd_ready_o=1.

Source files
------------

// File: rtl/prim_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : prim_cmd_sequencer_if
//  Brief    : Host command push and renderer issue signals of the sequencer.
//  Revision : 1.0  initial release
// ============================================================================
interface prim_cmd_sequencer_if;
    logic [15:0] cmd_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [15:0] rndr_cmd_o;
    logic        rndr_cmd_valid_o;
    logic        rndr_done_i;

    modport master (
        output cmd_i, cmd_valid_i, rndr_done_i,
        input  cmd_ready_o, rndr_cmd_o, rndr_cmd_valid_o
    );

    modport slave (
        input  cmd_i, cmd_valid_i, rndr_done_i,
        output cmd_ready_o, rndr_cmd_o, rndr_cmd_valid_o
    );
endinterface
`default_nettype wire

// File: rtl/prim_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : prim_cmd_sequencer
//  Brief    : Command FIFO that issues renderer commands one per cycle and
//             holds issue after a start until line done or watchdog expiry.
//  Revision : 1.0  initial release
// ============================================================================
module prim_cmd_sequencer #(
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  wire logic                   clk,
    input  wire logic                   reset_i,
    prim_cmd_sequencer_if.slave         bus,
    input  wire logic                   flush_i,
    input  wire logic                   clear_err_i,
    output logic [$clog2(DEPTH):0]      level_o,
    output logic                        busy_o,
    output logic                        overflow_o,
    output logic                        timeout_o
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [c_CW-1:0] c_TO_LAST = c_CW'(TIMEOUT_CYCLES - 1);
    localparam logic [0:0] c_ST_ISSUE = 1'b0;
    localparam logic [0:0] c_ST_WAIT  = 1'b1;

    logic [15:0]     r_mem [DEPTH];
    logic [c_AW:0]   r_wptr;
    logic [c_AW:0]   r_rptr;
    logic [0:0]      r_state;
    logic [c_CW-1:0] r_cnt;
    logic [15:0]     r_cmd;
    logic            r_valid;
    logic            r_ovf;
    logic            r_to;

    logic            w_empty;
    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic            w_drop;
    logic            w_to_hit;
    logic [15:0]     w_head;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                     (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
    assign w_head  = r_mem[r_rptr[c_AW-1:0]];

    // Flush discards any concurrent push without counting it as an overflow.
    assign w_push   = bus.cmd_valid_i && !w_full && !flush_i;
    assign w_drop   = bus.cmd_valid_i &&  w_full && !flush_i;
    assign w_pop    = (r_state == c_ST_ISSUE) && !w_empty && !flush_i;
    assign w_to_hit = (TIMEOUT_CYCLES != 0) && (r_state == c_ST_WAIT) &&
                      !bus.rndr_done_i && !flush_i && (r_cnt == c_TO_LAST);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[c_AW-1:0]] <= bus.cmd_i;
        end
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_state <= c_ST_ISSUE;
            r_cnt   <= '0;
            r_cmd   <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_to    <= 1'b0;
        end else begin
            r_ovf <= w_drop   | (r_ovf & ~clear_err_i);
            r_to  <= w_to_hit | (r_to  & ~clear_err_i);
            if (flush_i) begin
                r_rptr  <= r_wptr;
                r_state <= c_ST_ISSUE;
                r_cnt   <= '0;
                r_valid <= 1'b0;
            end else begin
                r_valid <= w_pop;
                if (w_push) begin
                    r_wptr <= r_wptr + 1'b1;
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + 1'b1;
                    r_cmd  <= w_head;
                    if (w_head[15:12] == 4'hF) begin
                        r_state <= c_ST_WAIT;
                        r_cnt   <= '0;
                    end
                end
                if (r_state == c_ST_WAIT) begin
                    if (bus.rndr_done_i || w_to_hit) begin
                        r_state <= c_ST_ISSUE;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign bus.cmd_ready_o      = !w_full && !reset_i;
    assign bus.rndr_cmd_o       = r_cmd;
    assign bus.rndr_cmd_valid_o = r_valid;
    assign level_o              = r_wptr - r_rptr;
    assign busy_o               = (r_state == c_ST_WAIT) || !w_empty || r_valid;
    assign overflow_o           = r_ovf;
    assign timeout_o            = r_to;

endmodule
`default_nettype wire

// File: tb/tb_prim_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prim_cmd_sequencer
//  Brief    : Randomized and directed scoreboard bench for prim_cmd_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_prim_cmd_sequencer;

    localparam int DEPTH = 8;
    localparam int TO    = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       clear;
    logic [3:0] level;
    logic       busy;
    logic       ovf;
    logic       to;

    prim_cmd_sequencer_if bus();

    prim_cmd_sequencer #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset_i     (rst),
        .bus         (bus),
        .flush_i     (flush),
        .clear_err_i (clear),
        .level_o     (level),
        .busy_o      (busy),
        .overflow_o  (ovf),
        .timeout_o   (to)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a word queue plus a "waiting for done" flag.
    logic [15:0] mq[$];
    logic [15:0] exp_q[$];
    bit          m_wait, m_ovf, m_to, m_strobe, m_acc, m_drop, m_hit;
    int          m_cnt;
    logic [15:0] m_w;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            exp_q.delete();
            m_wait = 0; m_cnt = 0; m_ovf = 0; m_to = 0; m_strobe = 0;
        end else begin
            m_drop = 0;
            m_hit  = 0;
            if (flush) begin
                mq.delete();
                m_wait = 0; m_cnt = 0; m_strobe = 0;
            end else begin
                m_acc  = bus.cmd_valid_i && (mq.size() < DEPTH);
                m_drop = bus.cmd_valid_i && !m_acc;
                m_strobe = 0;
                if (m_wait) begin
                    if (bus.rndr_done_i) m_wait = 0;
                    else if (m_cnt == TO - 1) begin m_wait = 0; m_hit = 1; end
                    else m_cnt++;
                end else if (mq.size() > 0) begin
                    m_w = mq.pop_front();
                    exp_q.push_back(m_w);
                    m_strobe = 1;
                    if (m_w[15:12] == 4'hF) begin m_wait = 1; m_cnt = 0; end
                end
                if (m_acc) mq.push_back(bus.cmd_i);
            end
            m_ovf = m_drop | (m_ovf & !clear);
            m_to  = m_hit  | (m_to  & !clear);
        end
    end

    int cyc_n = 0;
    int n_strobes = 0;
    int t_f000 = 0;
    int t_0001 = 0;

    always @(negedge clk) begin
        cyc_n++;
        check("cmd_ready", 32'(bus.cmd_ready_o), 32'(!rst && mq.size() < DEPTH));
        check("level", 32'(level), 32'(mq.size()));
        check("busy", 32'(busy), 32'(m_wait || mq.size() > 0 || m_strobe));
        check("overflow", 32'(ovf), 32'(m_ovf));
        check("timeout", 32'(to), 32'(m_to));
        check("strobe", 32'(bus.rndr_cmd_valid_o), 32'(m_strobe));
        if (bus.rndr_cmd_valid_o) begin
            n_strobes++;
            if (bus.rndr_cmd_o == 16'hF000) t_f000 = cyc_n;
            if (bus.rndr_cmd_o == 16'h0001) t_0001 = cyc_n;
            if (exp_q.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL rndr_cmd: got %0h expected none", bus.rndr_cmd_o);
            end else begin
                check("rndr_cmd", 32'(bus.rndr_cmd_o), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic cyc(input bit v, input logic [15:0] w, input bit d, input bit f, input bit c);
        bus.cmd_valid_i = v;
        bus.cmd_i       = w;
        bus.rndr_done_i = d;
        flush           = f;
        clear           = c;
        @(posedge clk);
        #2;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_i       = 16'h0;
        bus.rndr_done_i = 1'b0;
        flush           = 1'b0;
        clear           = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 16'h0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    logic [15:0] seq [6] = '{16'h0010, 16'h1020, 16'h2030, 16'h3040, 16'h40FF, 16'hF000};
    int   s0;
    logic ovf_before;

    initial begin
        rst = 1'b1; flush = 0; clear = 0;
        bus.cmd_valid_i = 0; bus.cmd_i = 0; bus.rndr_done_i = 0;
        #13;
        check("rst_level", 32'(level), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(bus.rndr_cmd_valid_o), 32'd0);
        check("rst_cmd", 32'(bus.rndr_cmd_o), 32'd0);
        check("rst_ready", 32'(bus.cmd_ready_o), 32'd0);
        #10 rst = 1'b0;
        @(posedge clk); #2;
        check("ready_after_rst", 32'(bus.cmd_ready_o), 32'd1);

        // Six back-to-back commands ending with a start.
        s0 = n_strobes;
        for (int i = 0; i < 6; i++) cyc(1, seq[i], 0, 0, 0);
        idle(3);
        check("burst_strobes", 32'(n_strobes - s0), 32'd6);
        check("burst_busy_wait", 32'(busy), 32'd1);

        // Queued word held until done.
        s0 = n_strobes;
        cyc(1, 16'h0005, 0, 0, 0);
        idle(4);
        check("held_while_wait", 32'(n_strobes - s0), 32'd0);
        cyc(0, 16'h0, 1, 0, 0);
        idle(3);
        check("after_done", 32'(n_strobes - s0), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);

        // Overflow while stalled.
        cyc(1, 16'hF000, 0, 0, 0);
        idle(2);
        for (int i = 0; i < 9; i++) begin
            cyc(1, 16'h0100 + 16'(i), 0, 0, 0);
            if (i == 7) check("full_ready", 32'(bus.cmd_ready_o), 32'd0);
        end
        check("full_level", 32'(level), 32'd8);
        check("ovf_set", 32'(ovf), 32'd1);
        cyc(0, 16'h0, 0, 0, 1);
        check("ovf_clear", 32'(ovf), 32'd0);
        s0 = n_strobes;
        cyc(0, 16'h0, 1, 0, 0);
        idle(12);
        check("drain_8", 32'(n_strobes - s0), 32'd8);

        // Watchdog expiry: exactly TO cycles in wait.
        cyc(1, 16'hF000, 0, 0, 0);
        cyc(1, 16'h0001, 0, 0, 0);
        idle(20);
        check("to_gap", 32'(t_0001 - t_f000), 32'(TO + 1));
        check("to_set", 32'(to), 32'd1);
        cyc(0, 16'h0, 0, 0, 1);
        check("to_clear", 32'(to), 32'd0);

        // Done on the last wait cycle beats the watchdog.
        cyc(1, 16'hF000, 0, 0, 0);
        cyc(1, 16'h0001, 0, 0, 0);
        idle(15);
        cyc(0, 16'h0, 1, 0, 0);
        idle(4);
        check("done_gap", 32'(t_0001 - t_f000), 32'(TO + 1));
        check("done_no_to", 32'(to), 32'd0);

        // Flush with queued words while waiting.
        cyc(1, 16'hF000, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 16'h0300 + 16'(i), 0, 0, 0);
        check("pre_flush_level", 32'(level), 32'd5);
        ovf_before = ovf;
        cyc(1, 16'h7777, 0, 1, 0);
        check("flush_level", 32'(level), 32'd0);
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_valid", 32'(bus.rndr_cmd_valid_o), 32'd0);
        check("flush_ovf", 32'(ovf), 32'(ovf_before));
        s0 = n_strobes;
        cyc(1, 16'h0123, 0, 0, 0);
        idle(3);
        check("post_flush_issue", 32'(n_strobes - s0), 32'd1);

        // Asynchronous reset mid-drain.
        for (int i = 0; i < 4; i++) cyc(1, 16'h0201 + 16'(i), 0, 0, 0);
        #1 rst = 1'b1;
        #1;
        check("arst_valid", 32'(bus.rndr_cmd_valid_o), 32'd0);
        check("arst_cmd", 32'(bus.rndr_cmd_o), 32'd0);
        check("arst_level", 32'(level), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_ready", 32'(bus.cmd_ready_o), 32'd0);
        #4 rst = 1'b0;
        @(posedge clk); #2;
        check("arst_rel_ready", 32'(bus.cmd_ready_o), 32'd1);
        check("arst_rel_level", 32'(level), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [15:0] w;
            if ($urandom_range(0, 7) == 0) w = {4'hF, 12'($urandom)};
            else w = {4'($urandom_range(0, 4)), 12'($urandom)};
            cyc(1'($urandom_range(0, 1)), w, ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0));
        end
        for (int i = 0; i < 40; i++) cyc(0, 16'h0, 1, 0, 0);
        check("final_level", 32'(level), 32'd0);
        check("final_scoreboard", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
